// File: rtl/btn_debounce_pkg.sv
// Board-level constants shared by the button front end and its users.
package btn_debounce_pkg;

    localparam int unsigned NUM_BTN = 2;
    localparam logic [NUM_BTN-1:0] BTN_RST_LVL = '0;
    localparam int unsigned CLK_SYS_HZ = 25_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stability counter, level and edge pulses.
module btn_debounce_ch #(
    parameter int unsigned DEB_TICKS = 16,
    parameter logic        RST_LVL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(DEB_TICKS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_TICKS - 1);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Any sample matching the current level discards partial progress.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CntMax) begin
                level_d = s2_q;
                cnt_d   = '0;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= RST_LVL;
            s2_q    <= RST_LVL;
            level_q <= RST_LVL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button synchronizer/debouncer: shared tick prescaler plus per-channel logic.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned       NUM_CH    = NUM_BTN,
    parameter int unsigned       DEB_TICKS = 16,
    parameter int unsigned       TICK_DIV  = CLK_SYS_HZ / 1000,
    parameter logic [NUM_CH-1:0] RST_LVL   = NUM_CH'(BTN_RST_LVL)
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic [NUM_CH-1:0] btn_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
);

    logic tick;

    if (TICK_DIV == 1) begin : g_no_div
        assign tick = 1'b1;
    end else begin : g_div
        localparam int unsigned DivW = $clog2(TICK_DIV);
        localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

        logic [DivW-1:0] div_q, div_d;

        always_comb begin
            div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
        end

        always_ff @(posedge clk_sys or negedge rst_sys_n) begin
            if (!rst_sys_n) begin
                div_q <= '0;
            end else begin
                div_q <= div_d;
            end
        end

        assign tick = (div_q == DivMax);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_TICKS(DEB_TICKS),
            .RST_LVL  (RST_LVL[i])
        ) u_ch (
            .clk_i  (clk_sys),
            .rst_ni (rst_sys_n),
            .tick_i (tick),
            .btn_i  (btn_i[i]),
            .level_o(level_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

endmodule
